// File: rtl/hbridge_arbiter.sv
// Three-requester H-bridge arbiter with fixed priority and a bridge-off dead
// interval before any new direction pattern is driven onto the pins.
module hbridge_arbiter #(
  parameter int DEAD_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       req2,
  input  logic [3:0] dir0,
  input  logic [3:0] dir1,
  input  logic [3:0] dir2,
  input  logic       ena0,
  input  logic       ena1,
  input  logic       ena2,
  input  logic       enb0,
  input  logic       enb1,
  input  logic       enb2,
  output logic [2:0] gnt,
  output logic       hbEnA,
  output logic       hbEnB,
  output logic       hbIn1,
  output logic       hbIn2,
  output logic       hbIn3,
  output logic       hbIn4,
  output logic [1:0] act_id,
  output logic       illegal
);

  typedef enum logic [1:0] {IDLE, DEAD, DRIVE} stateT;

  localparam logic [19:0] DEAD_LOAD = 20'(DEAD_CYCLES - 1);

  stateT       state;
  logic [19:0] deadCnt;
  logic [3:0]  dirLatch;

  logic        winValid;
  logic [1:0]  winId;
  logic [3:0]  winDirRaw;
  logic        winEnaRaw;
  logic        winEnbRaw;
  logic        winIllegal;
  logic [3:0]  winDir;
  logic        winEna;
  logic        winEnb;
  logic [2:0]  winOneHot;

  // Fixed-priority winner; an illegal pattern (shoot-through on either leg)
  // is replaced by an all-off request so it can never reach the pins.
  always_comb begin
    winValid  = 1'b1;
    winId     = 2'd3;
    winDirRaw = 4'b0000;
    winEnaRaw = 1'b0;
    winEnbRaw = 1'b0;
    if (req0) begin
      winId = 2'd0; winDirRaw = dir0; winEnaRaw = ena0; winEnbRaw = enb0;
    end else if (req1) begin
      winId = 2'd1; winDirRaw = dir1; winEnaRaw = ena1; winEnbRaw = enb1;
    end else if (req2) begin
      winId = 2'd2; winDirRaw = dir2; winEnaRaw = ena2; winEnbRaw = enb2;
    end else begin
      winValid = 1'b0;
    end
    winIllegal = (winDirRaw[3] & winDirRaw[2]) | (winDirRaw[1] & winDirRaw[0]);
    winDir     = winIllegal ? 4'b0000 : winDirRaw;
    winEna     = winEnaRaw & ~winIllegal;
    winEnb     = winEnbRaw & ~winIllegal;
    winOneHot  = 3'b000;
    if (winValid) winOneHot[winId] = 1'b1;
  end

  // Outputs default to bridge-off each cycle; only DRIVE paths override them,
  // so every exit from DRIVE lands on zero pins without extra bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      deadCnt  <= '0;
      dirLatch <= 4'b0000;
      gnt      <= 3'b000;
      act_id   <= 2'd3;
      illegal  <= 1'b0;
      {hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4} <= 6'b0;
    end else begin
      illegal <= winValid & winIllegal;
      gnt     <= 3'b000;
      act_id  <= 2'd3;
      {hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4} <= 6'b0;
      case (state)
        IDLE: begin
          if (winValid) begin
            state   <= DEAD;
            deadCnt <= DEAD_LOAD;
          end
        end
        DEAD: begin
          if (!winValid) begin
            state <= IDLE;
          end else if (deadCnt == '0) begin
            state    <= DRIVE;
            dirLatch <= winDir;
            gnt      <= winOneHot;
            act_id   <= winId;
            {hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4} <= {winEna, winEnb, winDir};
          end else begin
            deadCnt <= deadCnt - 20'd1;
          end
        end
        DRIVE: begin
          if (!winValid) begin
            state <= IDLE;
          end else if (winDir != dirLatch) begin
            state   <= DEAD;
            deadCnt <= DEAD_LOAD;
          end else begin
            // Same pattern: ownership may hop between requesters with no gap.
            gnt    <= winOneHot;
            act_id <= winId;
            {hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4} <= {winEna, winEnb, dirLatch};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hbridge_arbiter.md
HBRIDGE_ARBITER -- requirements
Module: hbridge_arbiter

Interface
REQ-001 The block SHALL have one parameter: DEAD_CYCLES, default 50_000 (1 ms at 50 MHz), legal range 1..2^20-1, giving the bridge-off interval before any new direction is applied.
REQ-002 clk  in  1  system clock, 50 MHz; all logic is on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req0/req1/req2  in  1 each  motor requests; 0 = collision (highest priority), 1 = junction maneuver, 2 = line follower (lowest).
REQ-005 dir0/dir1/dir2  in  4 each  requested {in1,in2,in3,in4} pattern.
REQ-006 ena0..2, enb0..2  in  1 each  requested PWM enables for bridge sides A and B.
REQ-007 gnt  out  3  one-hot grant; bit n is set while requester n drives the bridge.
REQ-008 hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4  out  1 each  registered H-bridge pins.
REQ-009 act_id  out  2  owner index; 3 = none.
REQ-010 illegal  out  1  one-cycle pulse when the winner's dir is illegal.

Function
REQ-011 Winner W SHALL be the lowest-index requester with req=1 in the current cycle; W = none if no req is set.
REQ-012 Any dir with in1&in2=1 or in3&in4=1 SHALL be illegal; it SHALL be treated as dir 0000 with ena=enb=0, and illegal SHALL pulse for each cycle in which W's dir is illegal.
REQ-013 The block SHALL have three states: IDLE, DEAD, DRIVE; all outputs SHALL be registered with 1-cycle latency from sampled inputs.
REQ-014 In IDLE, all six bridge pins = 0, gnt = 000 and act_id = 3; if W exists, the block SHALL go to DEAD with the counter loaded to DEAD_CYCLES-1.
REQ-015 In DEAD, all six bridge pins = 0 and gnt = 000, and the counter SHALL decrement once per cycle.
REQ-016 In DEAD, if no req is set, the block SHALL go to IDLE next cycle; W may change freely while counting, and the counter SHALL NOT restart.
REQ-017 In DEAD with counter = 0 and W existing, the block SHALL go to DRIVE with act = W, latched dir L = dir_W, gnt = onehot(W), and pins = {ena_W, enb_W, dir_W}.
REQ-018 In DRIVE with W = none, the block SHALL go to IDLE, with pins 0 on the next cycle and no dead time.
REQ-019 In DRIVE with W = act and dir_W = L, the pins SHALL track ena_W/enb_W with 1-cycle latency.
REQ-020 In DRIVE with dir_W != L (same owner or a different one), the block SHALL go to DEAD (counter = DEAD_CYCLES-1) and gnt SHALL clear.
REQ-021 In DRIVE with W != act and dir_W = L, ownership SHALL switch in one cycle: gnt and act_id move to W, and the pins take W's enables, with no dead time.
REQ-022 A lower-priority request SHALL never displace an active higher-priority owner; a higher-priority request SHALL preempt on the next cycle per REQ-020/021.
REQ-023 hbIn1&hbIn2 and hbIn3&hbIn4 SHALL never be 1 simultaneously.
REQ-024 Every change of any hbIn pin SHALL be preceded by at least DEAD_CYCLES cycles with all pins 0, except a transition to 0000.
REQ-025 gnt SHALL be zero or one-hot at all times, and act_id SHALL always equal its index (or 3 when gnt = 000).

Reset
REQ-026 With rst=1 at a rising edge, next cycle the state SHALL be IDLE, counter = 0, L = 0000, gnt = 000, act_id = 3, illegal = 0 and all bridge pins = 0, regardless of prior state (including mid-DEAD or mid-DRIVE).
REQ-027 After rst falls, a pending req SHALL still serve a full DEAD interval before driving.

Verification (DEAD_CYCLES = 4)
REQ-028 req2=1, dir2=0110, ena2=enb2=1 from IDLE -> 4 cycles of zeros, then gnt=100, act_id=2, pins EnA=EnB=1, In=0110; PWM toggles on ena2 appear 1 cycle later.
REQ-029 While req2 is driving 0110, assert req0 with dir0=1001 -> next cycle gnt=000 and pins 0 for 4 cycles, then gnt=001 and In=1001; req2 is never re-granted while req0=1.
REQ-030 While req2 is driving 0110, assert req1 with dir1=0110 -> gnt changes 100->010 in one cycle with no zero interval; dropping req1 returns the bridge to req2 in one cycle.
REQ-031 Owner req2 changes dir2 0110->1010 -> 4 zero cycles, then In=1010; req2 drives dir2=1100 -> illegal pulses and pins stay 0; req2 drops -> IDLE next cycle.
REQ-032 Assert rst mid-DEAD and mid-DRIVE -> all outputs 0 and act_id=3 the next cycle; with req held, the full 4-cycle DEAD repeats after rst falls.
REQ-033 A random req/dir/ena stimulus of 10^5 cycles SHALL pass checker assertions for REQ-023, REQ-024 and REQ-025.
